// File: rtl/thread_fetch_scheduler.sv
// thread_fetch_scheduler: round-robin fine-grained multithread fetch scheduler.
// Keeps one PC per hardware thread and issues one fetch per unstalled cycle.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   thread_en         : per-thread run mask (NUM_THREADS bits)
//   stall             : downstream hold; freezes scheduler state
//   redirect_valid    : load redirect_pc into pc[redirect_thread]
//   redirect_thread   : thread targeted by the redirect
//   redirect_pc       : new PC for the redirected thread
//   fetch_valid       : registered, fetch_pc/fetch_thread_id are a real fetch
//   fetch_pc          : registered instruction address
//   fetch_thread_id   : registered thread of the current fetch
//   pipe_en           : fetch/decode pipeline register enable (~stall)
module thread_fetch_scheduler #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [(1<<THREAD_BITS)-1:0] thread_en,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [THREAD_BITS-1:0]     redirect_thread,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       fetch_valid,
  output logic [INST_ADDR_WIDTH-1:0] fetch_pc,
  output logic [THREAD_BITS-1:0]     fetch_thread_id,
  output logic                       pipe_en
);

  localparam int NUM_THREADS = 1 << THREAD_BITS;

  typedef logic [INST_ADDR_WIDTH-1:0] pc_t;
  typedef logic [THREAD_BITS-1:0]     tid_t;

  // Each thread starts at the base of its own memory partition.
  function automatic pc_t pc_base(input int i);
    return pc_t'(i) << (INST_ADDR_WIDTH - THREAD_BITS);
  endfunction

  pc_t  pc_q [NUM_THREADS];
  pc_t  pc_d [NUM_THREADS];
  tid_t last_grant_q;
  tid_t last_grant_d;
  logic fetch_valid_q;
  logic fetch_valid_d;
  pc_t  fetch_pc_q;
  pc_t  fetch_pc_d;
  tid_t fetch_tid_q;
  tid_t fetch_tid_d;

  logic [NUM_THREADS-1:0] eligible;
  logic                   found;
  tid_t                   grant;
  tid_t                   idx;

  // A thread being redirected this cycle sits out arbitration so its
  // stale PC is never fetched and the increment never races the load.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = thread_en[i] &
        ~(redirect_valid & (redirect_thread == tid_t'(i)));
    end
  end

  // Round-robin search beginning just after the last grant.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx = last_grant_q + tid_t'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    pc_d          = pc_q;
    last_grant_d  = last_grant_q;
    fetch_valid_d = fetch_valid_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_tid_d   = fetch_tid_q;

    if (!stall) begin
      if (found) begin
        fetch_valid_d = 1'b1;
        fetch_pc_d    = pc_q[grant];
        fetch_tid_d   = grant;
        pc_d[grant]   = pc_q[grant] + pc_t'(1);
        last_grant_d  = grant;
      end else begin
        fetch_valid_d = 1'b0;
      end
    end

    // Redirects land even while stalled.
    if (redirect_valid) begin
      pc_d[redirect_thread] = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= pc_base(i);
      end
      last_grant_q  <= tid_t'(NUM_THREADS - 1);
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_tid_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= pc_d[i];
      end
      last_grant_q  <= last_grant_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_tid_q   <= fetch_tid_d;
    end
  end

  assign fetch_valid     = fetch_valid_q;
  assign fetch_pc        = fetch_pc_q;
  assign fetch_thread_id = fetch_tid_q;
  assign pipe_en         = ~stall;

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// tb_thread_fetch_scheduler: directed scoreboard bench.
// Stimulus queues expected outputs; a monitor compares them each cycle.
module tb_thread_fetch_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] thread_en = 4'b0000;
  logic       stall = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [1:0] redirect_thread = 2'd0;
  logic [8:0] redirect_pc = 9'd0;
  logic       fetch_valid;
  logic [8:0] fetch_pc;
  logic [1:0] fetch_thread_id;
  logic       pipe_en;

  thread_fetch_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .thread_en       (thread_en),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_thread (redirect_thread),
    .redirect_pc     (redirect_pc),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .fetch_thread_id (fetch_thread_id),
    .pipe_en         (pipe_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         v;
    logic [1:0] tid;
    logic [8:0] pc;
    bit         pe;
  } exp_t;

  exp_t  expq[$];
  string nameq[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Monitor: compare the head of the scoreboard in its target cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      while (expq.size() > 0 && expq[0].at < cyc) begin
        e = expq.pop_front();
        n = nameq.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: expectation for cycle %0d never sampled", n, e.at);
      end
      if (expq.size() > 0 && expq[0].at == cyc) begin
        e = expq.pop_front();
        n = nameq.pop_front();
        vectors++;
        if (fetch_valid !== e.v || fetch_pc !== e.pc ||
            fetch_thread_id !== e.tid || pipe_en !== e.pe) begin
          miscompares++;
          $display("FAIL %s: got v=%0b tid=%0d pc=%03h pe=%0b, want v=%0b tid=%0d pc=%03h pe=%0b",
                   n, fetch_valid, fetch_thread_id, fetch_pc, pipe_en,
                   e.v, e.tid, e.pc, e.pe);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the output expected after the edge.
  task automatic apply(input bit rs, input logic [3:0] en, input bit st,
                       input bit rv, input logic [1:0] rt,
                       input logic [8:0] rp, input bit ev,
                       input logic [1:0] et, input logic [8:0] ep,
                       input string nm);
    exp_t e;
    @(negedge clk);
    reset           = rs;
    thread_en       = en;
    stall           = st;
    redirect_valid  = rv;
    redirect_thread = rt;
    redirect_pc     = rp;
    e.at  = cyc + 1;
    e.v   = ev;
    e.tid = et;
    e.pc  = ep;
    e.pe  = !st;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  task automatic run(input logic [3:0] en, input bit ev,
                     input logic [1:0] et, input logic [8:0] ep,
                     input string nm);
    apply(1'b0, en, 1'b0, 1'b0, 2'd0, 9'h000, ev, et, ep, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    apply(1, 4'b0000, 0, 0, 0, 9'h000, 0, 0, 9'h000, "reset0");
    apply(1, 4'b0000, 0, 0, 0, 9'h000, 0, 0, 9'h000, "reset1");

    // all threads round robin
    run(4'b1111, 1, 0, 9'h000, "rr_t0");
    run(4'b1111, 1, 1, 9'h080, "rr_t1");
    run(4'b1111, 1, 2, 9'h100, "rr_t2");
    run(4'b1111, 1, 3, 9'h180, "rr_t3");
    run(4'b1111, 1, 0, 9'h001, "rr_t0_inc");
    run(4'b1111, 1, 1, 9'h081, "rr_t1_inc");

    // sparse mask from fresh reset, then all disabled
    apply(1, 4'b1111, 0, 0, 0, 9'h000, 0, 0, 9'h000, "reset2");
    run(4'b1010, 1, 1, 9'h080, "mask_t1a");
    run(4'b1010, 1, 3, 9'h180, "mask_t3a");
    run(4'b1010, 1, 1, 9'h081, "mask_t1b");
    run(4'b1010, 1, 3, 9'h181, "mask_t3b");
    run(4'b0000, 0, 3, 9'h181, "none_a");
    run(4'b0000, 0, 3, 9'h181, "none_b");

    // stall mid-sequence
    run(4'b1111, 1, 0, 9'h000, "pre_stall_t0");
    run(4'b1111, 1, 1, 9'h082, "pre_stall_t1");
    apply(0, 4'b1111, 1, 0, 0, 9'h000, 1, 1, 9'h082, "stall_1");
    apply(0, 4'b1111, 1, 0, 0, 9'h000, 1, 1, 9'h082, "stall_2");
    apply(0, 4'b1111, 1, 0, 0, 9'h000, 1, 1, 9'h082, "stall_3");
    run(4'b1111, 1, 2, 9'h100, "post_stall_t2");
    run(4'b1111, 1, 3, 9'h182, "post_stall_t3");
    run(4'b1111, 1, 0, 9'h001, "post_stall_t0");

    // redirect thread 2 when it is next in line
    run(4'b1111, 1, 1, 9'h083, "pre_redir_t1");
    apply(0, 4'b1111, 0, 1, 2, 9'h055, 1, 3, 9'h183, "redir_skip_t2");
    run(4'b1111, 1, 0, 9'h002, "redir_t0");
    run(4'b1111, 1, 1, 9'h084, "redir_t1");
    run(4'b1111, 1, 2, 9'h055, "redir_t2_new");
    run(4'b1111, 1, 3, 9'h184, "redir_t3");
    run(4'b1111, 1, 0, 9'h003, "redir_t0b");
    run(4'b1111, 1, 1, 9'h085, "redir_t1b");
    run(4'b1111, 1, 2, 9'h056, "redir_t2_inc");

    // single thread, redirect under stall, PC wrap
    run(4'b0001, 1, 0, 9'h004, "single_a");
    run(4'b0001, 1, 0, 9'h005, "single_b");
    apply(0, 4'b0001, 1, 1, 0, 9'h1ff, 1, 0, 9'h005, "stall_redir");
    run(4'b0001, 1, 0, 9'h1ff, "wrap_top");
    run(4'b0001, 1, 0, 9'h000, "wrap_zero");
    run(4'b0001, 1, 0, 9'h001, "wrap_one");

    // reset overrides stall, redirect and enables
    apply(1, 4'b1111, 1, 1, 1, 9'h033, 0, 0, 9'h000, "reset_mid");
    run(4'b1111, 1, 0, 9'h000, "after_rst_t0");
    run(4'b1111, 1, 1, 9'h080, "after_rst_t1");

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    if (expq.size() != 0) begin
      vectors     += expq.size();
      miscompares += expq.size();
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
